// File: rtl/bmpasm_pkg.sv
// Shared bitmap definitions: geometry, assembler state encoding and the
// (row, col) -> bit offset mapping used by both the assembler and the bitmap
// register. The optional row-input mode is enabled by the macro BMPASM_ROWIN_EN.
package bmpasm_pkg;

  localparam int ROWS  = 64;
  localparam int COLS  = 24;
  localparam int BMP_W = ROWS * COLS;

`ifdef BMPASM_ROWIN_EN
  // The index register has to count 0..63 when rows are streamed in.
  localparam int IDX_W = 6;
`else
  localparam int IDX_W = 5;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit r*COLS+c of the flat bitmap holds row r, column c.
  function automatic int bit_offset(input int row, input int col);
    return row * COLS + col;
  endfunction

endpackage

// File: rtl/bmpasm_if.sv
// Column slice handshake bundle between a slice producer (master) and the
// bitmap assembler (slave).
interface bmpasm_if;
  import bmpasm_pkg::*;

  logic [ROWS-1:0]  colin;
  logic             colvalid;
  logic             colaccept;
  logic [IDX_W-1:0] colindex;

  modport master (output colin, output colvalid, input colaccept, input colindex);
  modport slave  (input colin, input colvalid, output colaccept, output colindex);

endinterface

// File: rtl/bmpasm_colwrite.sv
// Combinational column scatter: spreads one 64-bit column slice across the
// flat bitmap and flags which bitmap bits belong to the selected column.
// Slice bit 63 lands in row 0, slice bit 0 in row 63.
module bmpasm_colwrite
  import bmpasm_pkg::*;
(
  input  logic [4:0]       col,
  input  logic [ROWS-1:0]  colin,
  output logic [BMP_W-1:0] mask,
  output logic [BMP_W-1:0] wdata
);

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    for (genvar gj = 0; gj < COLS; gj++) begin : g_col
      localparam int OFF = bit_offset(gi, gj);
      assign mask[OFF]  = (col == 5'(gj));
      assign wdata[OFF] = colin[ROWS-1-gi];
    end
  end

endmodule

// File: rtl/bmpasm.sv
// Bitmap assembler: collects 24 column slices (column 23 first, column 0 last)
// into a 24x64 bitmap and pulses bmpvalid for one cycle once it is complete.
// A start at any time restarts assembly with a cleared bitmap.
// With BMPASM_ROWIN_EN defined, a row mode taking 64 row slices (row 0 first)
// is added, selected by rowmode sampled together with start.
module bmpasm
  import bmpasm_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef BMPASM_ROWIN_EN
  input  logic             rowmode,
  input  logic [COLS-1:0]  rowin,
  input  logic             rowvalid,
`endif
  bmpasm_if.slave          col,
  output logic             busy,
  output logic [BMP_W-1:0] bmpout,
  output logic             bmpvalid
);

  state_t           state_reg, state_next;
  logic [BMP_W-1:0] data_reg, data_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [BMP_W-1:0] col_mask, col_wdata;
  logic             handshake;
  logic             last_slice;
  logic [IDX_W-1:0] start_idx;

  bmpasm_colwrite u_colwrite (
    .col   (idx_reg[4:0]),
    .colin (col.colin),
    .mask  (col_mask),
    .wdata (col_wdata)
  );

  // Status outputs come straight from registered state only.
  assign col.colaccept = (state_reg == ST_FILL);
  assign col.colindex  = idx_reg;
  assign busy          = (state_reg == ST_FILL);
  assign bmpvalid      = (state_reg == ST_DONE);
  assign bmpout        = data_reg;

`ifdef BMPASM_ROWIN_EN
  logic rowmode_reg, rowmode_next;

  assign handshake  = col.colaccept & (rowmode_reg ? rowvalid : col.colvalid);
  assign last_slice = rowmode_reg ? (idx_reg == IDX_W'(ROWS-1)) : (idx_reg == '0);
  assign start_idx  = rowmode ? '0 : IDX_W'(COLS-1);
`else
  assign handshake  = col.colaccept & col.colvalid;
  assign last_slice = (idx_reg == '0);
  assign start_idx  = IDX_W'(COLS-1);
`endif

  // State, bitmap and slice index registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      data_reg    <= '0;
      idx_reg     <= IDX_W'(COLS-1);
`ifdef BMPASM_ROWIN_EN
      rowmode_reg <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      data_reg    <= data_next;
      idx_reg     <= idx_next;
`ifdef BMPASM_ROWIN_EN
      rowmode_reg <= rowmode_next;
`endif
    end
  end

  // Next-state logic; start overrides any slice arriving in the same cycle.
  always_comb begin
    state_next   = state_reg;
    data_next    = data_reg;
    idx_next     = idx_reg;
`ifdef BMPASM_ROWIN_EN
    rowmode_next = rowmode_reg;
`endif
    if (start) begin
      state_next   = ST_FILL;
      data_next    = '0;
      idx_next     = start_idx;
`ifdef BMPASM_ROWIN_EN
      rowmode_next = rowmode;
`endif
    end else begin
      case (state_reg)
        ST_FILL: begin
          if (handshake) begin
`ifdef BMPASM_ROWIN_EN
            if (rowmode_reg) begin
              data_next[bit_offset(int'(idx_reg), 0) +: COLS] = rowin;
            end else begin
              data_next = (data_reg & ~col_mask) | (col_wdata & col_mask);
            end
`else
            data_next = (data_reg & ~col_mask) | (col_wdata & col_mask);
`endif
            if (last_slice) begin
              state_next = ST_DONE;
`ifdef BMPASM_ROWIN_EN
            end else if (rowmode_reg) begin
              idx_next = idx_reg + IDX_W'(1);
`endif
            end else begin
              idx_next = idx_reg - IDX_W'(1);
            end
          end
        end
        ST_DONE: state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bmpasm.sv
// Directed testbench for bmpasm: walking column, stalled handshake, restart
// mid-fill, start on the final slice, asynchronous reset, and row mode when
// built with BMPASM_ROWIN_EN.
module tb_bmpasm;
  import bmpasm_pkg::*;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             busy;
  logic [BMP_W-1:0] bmpout;
  logic             bmpvalid;
`ifdef BMPASM_ROWIN_EN
  logic             rowmode = 1'b0;
  logic [COLS-1:0]  rowin = '0;
  logic             rowvalid = 1'b0;
`endif

  bmpasm_if bus ();

  bmpasm dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
`ifdef BMPASM_ROWIN_EN
    .rowmode  (rowmode),
    .rowin    (rowin),
    .rowvalid (rowvalid),
`endif
    .col      (bus),
    .busy     (busy),
    .bmpout   (bmpout),
    .bmpvalid (bmpvalid)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int pulses = 0;
  logic [BMP_W-1:0] exp_bmp;
  int exp_idx;

  // Count bmpvalid pulses mid-cycle.
  always @(negedge clk) if (bmpvalid === 1'b1) pulses++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_bmp(input string tag, input logic [BMP_W-1:0] exp);
    int w;
    logic [63:0] ow, ew;
    w = 0;
    for (int i = BMP_W/64 - 1; i >= 0; i--)
      if (bmpout[i*64 +: 64] !== exp[i*64 +: 64]) w = i;
    ow = bmpout[w*64 +: 64];
    ew = exp[w*64 +: 64];
    vectors++;
    assert (bmpout === exp) else begin
      miscompares++;
      $error("FAIL %s word%0d observed=%h expected=%h", tag, w, ow, ew);
    end
  endtask

  initial begin
    bus.colin = '0;
    bus.colvalid = 1'b0;

    // Reset state.
    tick();
    check("rst_bmpout_zero", 64'(bmpout == '0), 64'd1);
    check("rst_colaccept", 64'(bus.colaccept), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_colindex", 64'(bus.colindex), 64'd23);
    check("rst_bmpvalid", 64'(bmpvalid), 64'd0);
    reset = 1'b0;
    tick();

    // Slices offered while idle are ignored.
    bus.colvalid = 1'b1;
    bus.colin = '1;
    tick();
    bus.colvalid = 1'b0;
    check_bmp("idle_ignore_bmp", '0);
    check("idle_ignore_idx", 64'(bus.colindex), 64'd23);

    // Walking column.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("walk_colaccept", 64'(bus.colaccept), 64'd1);
    check("walk_busy", 64'(busy), 64'd1);
    check("walk_idx0", 64'(bus.colindex), 64'd23);
    for (int k = 0; k < 24; k++) begin
      bus.colvalid = 1'b1;
      bus.colin = 64'h1 << k;
      tick();
      if (k < 23) begin
        check("walk_idx", 64'(bus.colindex), 64'(22 - k));
        check("walk_novalid", 64'(bmpvalid), 64'd0);
      end else begin
        check("walk_bmpvalid", 64'(bmpvalid), 64'd1);
        check("walk_done_accept", 64'(bus.colaccept), 64'd0);
        check("walk_done_busy", 64'(busy), 64'd0);
      end
    end
    bus.colvalid = 1'b0;
    exp_bmp = '0;
    for (int k = 0; k < 24; k++) exp_bmp[(63 - k) * 24 + (23 - k)] = 1'b1;
    check_bmp("walk_bmp", exp_bmp);
    tick();
    check("walk_pulse_end", 64'(bmpvalid), 64'd0);
    check("walk_pulses", 64'(pulses), 64'd1);
    check_bmp("walk_hold", exp_bmp);

    // Stalled handshake: valid on even cycles only.
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_idx = 23;
    bus.colin = '1;
    for (int i = 0; i < 47; i++) begin
      bus.colvalid = (i % 2 == 0);
      tick();
      if (i % 2 == 0) begin
        if (exp_idx != 0) begin
          exp_idx--;
          check("stall_idx_acc", 64'(bus.colindex), 64'(exp_idx));
        end else begin
          check("stall_bmpvalid", 64'(bmpvalid), 64'd1);
        end
      end else begin
        check("stall_idx_hold", 64'(bus.colindex), 64'(exp_idx));
        check("stall_busy", 64'(busy), 64'd1);
      end
    end
    bus.colvalid = 1'b0;
    check_bmp("stall_bmp_ones", '1);
    tick();
    check("stall_pulses", 64'(pulses), 64'd2);

    // Restart mid-fill.
    start = 1'b1;
    tick();
    start = 1'b0;
    bus.colin = '1;
    bus.colvalid = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    bus.colvalid = 1'b0;
    check_bmp("restart_bmp_zero", '0);
    check("restart_idx", 64'(bus.colindex), 64'd23);
    check("restart_busy", 64'(busy), 64'd1);
    check("restart_novalid", 64'(pulses), 64'd2);
    bus.colin = 64'hAAAA_AAAA_AAAA_AAAA;
    for (int i = 0; i < 24; i++) begin
      bus.colvalid = 1'b1;
      tick();
    end
    bus.colvalid = 1'b0;
    check("restart_bmpvalid", 64'(bmpvalid), 64'd1);
    exp_bmp = '0;
    for (int r = 0; r < 64; r += 2) exp_bmp[r * 24 +: 24] = '1;
    check_bmp("restart_bmp_aa", exp_bmp);
    tick();
    check("restart_pulses", 64'(pulses), 64'd3);

    // start coincident with the final handshake.
    start = 1'b1;
    tick();
    start = 1'b0;
    bus.colin = '1;
    bus.colvalid = 1'b1;
    for (int i = 0; i < 23; i++) tick();
    check("coin_idx_pre", 64'(bus.colindex), 64'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    bus.colvalid = 1'b0;
    check("coin_novalid", 64'(bmpvalid), 64'd0);
    check("coin_busy", 64'(busy), 64'd1);
    check("coin_accept", 64'(bus.colaccept), 64'd1);
    check("coin_idx", 64'(bus.colindex), 64'd23);
    check_bmp("coin_bmp_zero", '0);
    tick();
    check("coin_pulses", 64'(pulses), 64'd3);
    check("coin_busy2", 64'(busy), 64'd1);

    // Asynchronous reset mid-cycle during FILL.
    bus.colvalid = 1'b1;
    tick();
    tick();
    bus.colvalid = 1'b0;
    check("arst_idx_pre", 64'(bus.colindex), 64'd21);
    #2;
    reset = 1'b1;
    #1;
    check_bmp("arst_bmp_zero", '0);
    check("arst_colaccept", 64'(bus.colaccept), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_idx", 64'(bus.colindex), 64'd23);
    tick();
    reset = 1'b0;
    tick();
    check("arst_idle_busy", 64'(busy), 64'd0);
    check("arst_pulses", 64'(pulses), 64'd3);

`ifdef BMPASM_ROWIN_EN
    // Row mode: 64 rows with rowin = row index.
    rowmode = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    rowmode = 1'b0;
    check("row_idx0", 64'(bus.colindex), 64'd0);
    bus.colvalid = 1'b1;
    bus.colin = '1;
    for (int r = 0; r < 64; r++) begin
      rowvalid = 1'b1;
      rowin = COLS'(r);
      tick();
      if (r < 63) check("row_idx", 64'(bus.colindex), 64'(r + 1));
      else check("row_bmpvalid", 64'(bmpvalid), 64'd1);
    end
    rowvalid = 1'b0;
    bus.colvalid = 1'b0;
    exp_bmp = '0;
    for (int r = 0; r < 64; r++) exp_bmp[r * 24 +: 24] = COLS'(r);
    check_bmp("row_bmp", exp_bmp);
    tick();
    check("row_pulses", 64'(pulses), 64'd4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
